// File: rtl/tail_light_seq.sv
// Sequential turn/hazard/brake lamp controller for N lamps per side.
// Lamp patterns are registered from the next state; only brake reaches y combinationally.
module tail_light_seq #(
    parameter int N     = 3,
    parameter int DIV   = 1,
    parameter int DIV_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           left,
    input  logic           right,
    input  logic           brake,
    output logic [2*N-1:0] y,
    output logic           busy
);
    localparam int                SW       = $clog2(N + 2);
    localparam logic [SW-1:0]     STEP_ONE = SW'(1);
    localparam logic [SW-1:0]     STEP_OFF = SW'(N + 1);
    localparam logic [DIV_W-1:0]  CNT_LAST = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        HAZ   = 2'd3
    } state_t;

    typedef struct packed {
        state_t        state;
        logic [SW-1:0] step;
    } seq_t;

    seq_t             seq;
    seq_t             seq_next;
    logic [DIV_W-1:0] cnt;
    logic             tick;
    logic             illegal;
    logic             decode_now;
    logic [N-1:0]     lpat;
    logic [N-1:0]     rpat;
    logic             lact;
    logic             ract;

    // Bit i of the returned vector is lit when i < step during a lit phase.
    function automatic logic [N-1:0] thermo(input logic [SW-1:0] step);
        logic [N-1:0] t;
        logic         lit;
        lit = (step >= STEP_ONE) && (step < STEP_OFF);
        for (int i = 0; i < N; i++) begin
            t[i] = lit && (int'(step) > i);
        end
        return t;
    endfunction

    // Right side grows outward from y[N-1], i.e. the mirrored thermometer.
    function automatic logic [N-1:0] mirror(input logic [N-1:0] v);
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) begin
            m[N-1-i] = v[i];
        end
        return m;
    endfunction

    assign tick       = (cnt == CNT_LAST);
    assign illegal    = (seq.step > STEP_OFF) || ((seq.state == IDLE) != (seq.step == '0));
    assign decode_now = (seq.state == IDLE) || (seq.step == STEP_OFF);

    always_comb begin
        seq_next = seq;
        if (illegal) begin
            seq_next.state = IDLE;
            seq_next.step  = '0;
        end else if (tick) begin
            if (decode_now) begin
                seq_next.step = STEP_ONE;
                if (left && right) begin
                    seq_next.state = HAZ;
                end else if (left) begin
                    seq_next.state = LEFT;
                end else if (right) begin
                    seq_next.state = RIGHT;
                end else begin
                    seq_next.state = IDLE;
                    seq_next.step  = '0;
                end
            end else begin
                seq_next.step = seq.step + STEP_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            seq  <= '0;
            lpat <= '0;
            rpat <= '0;
            lact <= 1'b0;
            ract <= 1'b0;
            busy <= 1'b0;
        end else begin
            // An out-of-range count also folds back to zero.
            cnt  <= (cnt >= CNT_LAST) ? '0 : cnt + DIV_W'(1);
            seq  <= seq_next;
            lpat <= thermo(seq_next.step);
            rpat <= mirror(thermo(seq_next.step));
            lact <= (seq_next.state == LEFT) || (seq_next.state == HAZ);
            ract <= (seq_next.state == RIGHT) || (seq_next.state == HAZ);
            busy <= (seq_next.state != IDLE);
        end
    end

    // A side not owned by the running sequence shows brake on all its lamps.
    assign y[2*N-1:N] = lact ? lpat : {N{brake}};
    assign y[N-1:0]   = ract ? rpat : {N{brake}};

endmodule

// File: tb/tb_tail_light_seq.sv
// Bench for tail_light_seq: vector table, corner sequences, random run against a model,
// and a prescaled N=4 instance.
module tb_tail_light_seq;
    localparam int N3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst3, left3, right3, brake3;
    logic [5:0] y3;
    logic       busy3;
    logic       rst4, left4, right4, brake4;
    logic [7:0] y4;
    logic       busy4;

    tail_light_seq #(.N(3), .DIV(1), .DIV_W(8)) dut3 (
        .clk(clk), .reset(rst3), .left(left3), .right(right3),
        .brake(brake3), .y(y3), .busy(busy3)
    );

    tail_light_seq #(.N(4), .DIV(4), .DIV_W(8)) dut4 (
        .clk(clk), .reset(rst4), .left(left4), .right(right4),
        .brake(brake4), .y(y4), .busy(busy4)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [6:0] exp_q[$];

    typedef struct {
        logic       l;
        logic       r;
        logic       b;
        logic [5:0] y;
        logic       busy;
    } vec_t;
    vec_t tbl[$];

    // Reference model: mode 0 idle, 1 left, 2 right, 3 hazard; ph 0..N3+1.
    int m_mode;
    int m_ph;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic model_step(input logic l, input logic r);
        if (m_mode == 0 || m_ph == N3 + 1) begin
            m_ph = 1;
            if (l && r)  m_mode = 3;
            else if (l)  m_mode = 1;
            else if (r)  m_mode = 2;
            else begin
                m_mode = 0;
                m_ph   = 0;
            end
        end else begin
            m_ph++;
        end
    endtask

    function automatic logic [5:0] model_y(input logic b);
        int k;
        logic [2:0] lit, lh, rh;
        k   = (m_ph >= 1 && m_ph <= N3) ? m_ph : 0;
        lit = 3'((1 << k) - 1);
        lh  = (m_mode == 1 || m_mode == 3) ? lit : (b ? 3'b111 : 3'b000);
        rh  = (m_mode == 2 || m_mode == 3) ? 3'(lit << (N3 - k)) : (b ? 3'b111 : 3'b000);
        return {lh, rh};
    endfunction

    task automatic cycle(input logic l, input logic r, input logic b);
        left3  = l;
        right3 = r;
        brake3 = b;
        @(posedge clk);
        model_step(l, r);
        @(negedge clk);
    endtask

    task automatic add(input logic l, input logic r, input logic b,
                       input logic [5:0] yv, input logic bz);
        tbl.push_back('{l: l, r: r, b: b, y: yv, busy: bz});
    endtask

    initial begin
        rst3 = 1'b0; left3 = 1'b0; right3 = 1'b0; brake3 = 1'b0;
        rst4 = 1'b0; left4 = 1'b0; right4 = 1'b0; brake4 = 1'b0;
        m_mode = 0;
        m_ph   = 0;

        // Left held
        add(1,0,0,6'b001000,1); add(1,0,0,6'b011000,1); add(1,0,0,6'b111000,1);
        add(1,0,0,6'b000000,1); add(1,0,0,6'b001000,1);
        add(0,0,0,6'b011000,1); add(0,0,0,6'b111000,1); add(0,0,0,6'b000000,1);
        add(0,0,0,6'b000000,0);
        // Right pulsed
        add(0,1,0,6'b000100,1); add(0,0,0,6'b000110,1); add(0,0,0,6'b000111,1);
        add(0,0,0,6'b000000,1); add(0,0,0,6'b000000,0);
        // Hazard, brake mid-sequence has no effect
        add(1,1,0,6'b001100,1); add(1,1,0,6'b011110,1); add(1,1,1,6'b111111,1);
        add(1,1,1,6'b000000,1); add(1,1,0,6'b001100,1);
        add(0,0,0,6'b011110,1); add(0,0,0,6'b111111,1); add(0,0,0,6'b000000,1);
        add(0,0,0,6'b000000,0);
        // Brake in idle and with left
        add(0,0,1,6'b111111,0); add(1,0,1,6'b001111,1); add(0,0,1,6'b011111,1);
        add(0,0,1,6'b111111,1); add(0,0,1,6'b000111,1); add(0,0,1,6'b111111,0);
        // Left then right requested at step 2: left completes first
        add(1,0,0,6'b001000,1); add(0,1,0,6'b011000,1); add(0,1,0,6'b111000,1);
        add(0,1,0,6'b000000,1); add(0,1,0,6'b000100,1);
        add(0,0,0,6'b000110,1); add(0,0,0,6'b000111,1); add(0,0,0,6'b000000,1);
        add(0,0,0,6'b000000,0);

        repeat (2) @(negedge clk);
        check("reset_y3", 16'(y3), 16'h0000);
        check("reset_busy3", 16'(busy3), 16'h0000);
        check("reset_y4", 16'(y4), 16'h0000);
        brake3 = 1'b1;
        #1;
        check("reset_brake_y3", 16'(y3), 16'(6'b111111));
        brake3 = 1'b0;
        @(negedge clk);
        rst3 = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].l, tbl[i].r, tbl[i].b);
            check($sformatf("vec%0d_y", i), 16'(y3), 16'(tbl[i].y));
            check($sformatf("vec%0d_busy", i), 16'(busy3), 16'(tbl[i].busy));
        end

        // Asynchronous reset at step 2, before the next edge
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        check("pre_reset_step2", 16'(y3), 16'(6'b011000));
        #2 rst3 = 1'b0;
        #1;
        check("async_reset_y", 16'(y3), 16'h0000);
        check("async_reset_busy", 16'(busy3), 16'h0000);
        @(negedge clk);
        rst3   = 1'b1;
        m_mode = 0;
        m_ph   = 0;
        cycle(1, 0, 0);
        check("post_reset_first", 16'(y3), 16'(6'b001000));
        check("post_reset_busy", 16'(busy3), 16'h0001);

        // Random stimulus against the model
        for (int i = 0; i < 300; i++) begin
            logic l, r, b;
            logic [6:0] e;
            l = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 3) == 0);
            cycle(l, r, b);
            exp_q.push_back({(m_mode != 0), model_y(b)});
            e = exp_q.pop_front();
            check("rand_y", 16'(y3), 16'(e[5:0]));
            check("rand_busy", 16'(busy3), 16'(e[6]));
        end

        // N=4, DIV=4: each phase holds 4 clocks; first change at the 4th edge
        rst4  = 1'b1;
        left4 = 1'b1;
        for (int e = 1; e <= 28; e++) begin
            int p, s, k;
            logic [3:0] lit4;
            logic [7:0] exp8;
            logic       expb;
            @(posedge clk);
            @(negedge clk);
            p = e / 4;
            if (p == 0) begin
                exp8 = 8'h00;
                expb = 1'b0;
            end else begin
                s    = ((p - 1) % 5) + 1;
                k    = (s <= 4) ? s : 0;
                lit4 = 4'((1 << k) - 1);
                exp8 = {lit4, 4'b0000};
                expb = 1'b1;
            end
            check($sformatf("div4_e%0d_y", e), 16'(y4), 16'(exp8));
            check($sformatf("div4_e%0d_busy", e), 16'(busy4), 16'(expb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tail_light_seq.md
Name: tail_light_seq

Overview:
- Parametrised sequential turn/hazard/brake lamp controller for N lamps per side. Successor to the fixed 3-lamp-per-side tail-light FSM.
- Adds three things the earlier block lacked: a lamp-count parameter, a step-rate prescaler, and a brake override.
- Sits between the switch-input conditioning logic and the lamp drivers.

Parameters:
- N, 3, lamps per side (N >= 2); y is 2N bits wide.
- DIV, 1, clocks per sequence step (DIV >= 1); DIV=1 advances one step every clock.
- DIV_W, 8, prescaler counter width; must satisfy 2^DIV_W >= DIV.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- left  input  1  left turn request, level-sensitive.
- right  input  1  right turn request, level-sensitive.
- brake  input  1  brake request, level-sensitive.
- y  output  2N  lamp drives. y[2N-1:N] is the left side, y[N-1:0] is the right side. y[N] is the left inner lamp; y[N-1] is the right inner lamp.
- busy  output  1  1 when the state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, step=0, prescaler=0. y reflects brake only; busy=0.
- Prescaler: free-running counter from 0 to DIV-1, wrapping to 0. tick=1 when the count equals DIV-1. With DIV=1, tick is always 1. All state/step changes occur only on clock edges where tick=1.
- States: IDLE, LEFT, RIGHT, HAZ. step ranges 0..N+1.
  - Steps 1..N are lit phases.
  - Step N+1 is the all-off phase.
  - IDLE uses step=0.
- Request decode, used in IDLE and in the off phase, on a tick:
  - left&right -> HAZ, step 1.
  - left only -> LEFT, step 1.
  - right only -> RIGHT, step 1.
  - neither -> IDLE, step 0.
- In lit phases, on a tick: step increments. Inputs are ignored; a sequence is never aborted except by reset.
- Turn patterns at step k (1..N):
  - LEFT: the k inner-most left lamps are on, i.e. y[N+k-1:N]=1; the right side is zero.
  - RIGHT: y[N-1:N-k]=1; the left side is zero.
  - HAZ: both of the above together.
  - Off phase: all of y = 0.
- Brake override:
  - A side not driven by the current sequence shows all N lamps on while brake=1.
  - IDLE with brake=1 gives y = all ones.
  - In HAZ, brake has no effect.
  - During LEFT/RIGHT (including the off phase), the sequencing side follows its pattern and the other side follows brake.
  - brake is a combinational path to y.
- y otherwise decodes combinationally from registered state/step only (Moore). There is no left/right path to y.
- Latency (DIV=1): a request present at edge E produces the step-1 pattern immediately after E. A full sequence lasts N+1 clocks; an IDLE->LEFT->IDLE run occupies N+1 cycles.
- Continuous request: the off phase flows directly into step 1 of the newly decoded state. Switching direction is allowed only at the off phase.
- Reset mid-sequence: immediate IDLE and all counters cleared. After release, the first tick evaluates requests as in IDLE.
- Illegal state/step encodings recover to IDLE, step 0 on the next clock.
- busy=1 in LEFT/RIGHT/HAZ, including the off phase.

Test Plan (N=3 unless noted):
- Reset, then left=1 held, DIV=1: y = 001000, 011000, 111000, 000000, 001000, ... on successive clocks. busy=1 throughout.
- right pulsed for 1 clock: y = 000100, 000110, 000111, 000000, then IDLE with y=000000 and busy=0.
- left=right=1: y = 001100, 011110, 111111, 000000, repeating. Asserting brake mid-sequence leaves the pattern unchanged.
- brake=1 in IDLE gives y=111111. With brake=1 and left=1, y = 001111, 011111, 111111, 000111.
- left=1, then switch to right at step 2 (before the off phase): left completes 111000 then 000000, then right starts at 000100. Reset asserted at step 2 gives y=000000 asynchronously before the next edge.
- N=4, DIV=4, left=1: each pattern 00010000, 00110000, 01110000, 11110000, 00000000 holds for exactly 4 clocks. The first change occurs within 4 clocks of the request.
